// File: rtl/cnn1d_pkg.sv
// Shared definitions for the 1D CNN datapath: sample width, window FSM states,
// and a counter-width helper.
package cnn1d_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic {
        WIN_FILL,
        WIN_RUN
    } win_state_t;

    function automatic int clog2_max(input int a, input int b);
        return (a > b) ? $clog2(a) : $clog2(b);
    endfunction

endpackage

// File: rtl/sliding_window.sv
// Serial-to-parallel window framer feeding a neuron: one window per STRIDE samples once full.
// Optional frame support (win_last_in) is enabled by defining SLIDING_WINDOW_FRAME_EN.
module sliding_window
    import cnn1d_pkg::*;
#(
    parameter int WINDOW_SIZE = 3,
    parameter int STRIDE      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  win_ready_in,
    input  logic                  win_valid_in,
    input  logic [DATA_WIDTH-1:0] win_data_in,
`ifdef SLIDING_WINDOW_FRAME_EN
    input  logic                  win_last_in,
`endif
    input  logic                  win_ready_out,
    output logic                  win_valid_out,
    output logic [DATA_WIDTH-1:0] win_data_out [0:WINDOW_SIZE-1]
);

    localparam int CW = clog2_max(WINDOW_SIZE, STRIDE);
    localparam logic [CW-1:0] FILL_LAST   = CW'(WINDOW_SIZE - 1);
    localparam logic [CW-1:0] STRIDE_LAST = CW'(STRIDE - 1);

    win_state_t            state_q, state_d;
    logic [CW-1:0]         fill_q, fill_d;
    logic [CW-1:0]         stride_q, stride_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] sreg_q [0:WINDOW_SIZE-1];
    logic [DATA_WIDTH-1:0] sreg_d [0:WINDOW_SIZE-1];
    logic                  accept;
    logic                  emit;

    // A presented window blocks input until taken, so nothing is overwritten.
    assign win_ready_in  = ~rst & (~valid_q | win_ready_out);
    assign accept        = win_valid_in & win_ready_in;
    assign win_valid_out = valid_q;
    assign win_data_out  = sreg_q;

    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        stride_d = stride_q;
        sreg_d   = sreg_q;
        emit     = 1'b0;

        if (accept) begin
            for (int unsigned k = 0; k < WINDOW_SIZE - 1; k++) begin
                sreg_d[k] = sreg_q[k+1];
            end
            sreg_d[WINDOW_SIZE-1] = win_data_in;

            case (state_q)
                WIN_FILL: begin
                    if (fill_q == FILL_LAST) begin
                        emit     = 1'b1;
                        state_d  = WIN_RUN;
                        fill_d   = '0;
                        stride_d = '0;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                WIN_RUN: begin
                    if (stride_q == STRIDE_LAST) begin
                        emit     = 1'b1;
                        stride_d = '0;
                    end else begin
                        stride_d = stride_q + 1'b1;
                    end
                end
                default: state_d = WIN_FILL;
            endcase

`ifdef SLIDING_WINDOW_FRAME_EN
            // Frame end: emit decision above stands, then restart framing.
            if (win_last_in) begin
                state_d  = WIN_FILL;
                fill_d   = '0;
                stride_d = '0;
            end
`endif
        end

        if (emit) begin
            valid_d = 1'b1;
        end else if (win_ready_out) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= WIN_FILL;
            fill_q   <= '0;
            stride_q <= '0;
            valid_q  <= 1'b0;
            for (int unsigned k = 0; k < WINDOW_SIZE; k++) begin
                sreg_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            stride_q <= stride_d;
            valid_q  <= valid_d;
            sreg_q   <= sreg_d;
        end
    end

endmodule

// File: tb/tb_sliding_window.sv
// Bench for sliding_window: three configurations (W3/S1, W3/S2, W4/S5) checked against
// a sample-history scoreboard; frame test added when SLIDING_WINDOW_FRAME_EN is defined.
module tb_sliding_window;
    import cnn1d_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                  vin [3];
    logic [DATA_WIDTH-1:0] din [3];
    logic                  rdo [3];
    logic                  rin [3];
    logic                  vout [3];
`ifdef SLIDING_WINDOW_FRAME_EN
    logic                  lst [3];
`endif

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int W = (g == 2) ? 4 : 3;
        localparam int S = (g == 0) ? 1 : ((g == 1) ? 2 : 5);
        localparam logic [31:0] MASK = 32'((64'h1 << (W * 8)) - 1);

        logic [DATA_WIDTH-1:0] dout [0:W-1];
        logic [31:0]           dpk;

        sliding_window #(.WINDOW_SIZE(W), .STRIDE(S)) dut (
            .clk           (clk),
            .rst           (rst),
            .win_ready_in  (rin[g]),
            .win_valid_in  (vin[g]),
            .win_data_in   (din[g]),
`ifdef SLIDING_WINDOW_FRAME_EN
            .win_last_in   (lst[g]),
`endif
            .win_ready_out (rdo[g]),
            .win_valid_out (vout[g]),
            .win_data_out  (dout)
        );

        // Oldest sample in the most significant byte.
        always_comb begin
            dpk = '0;
            for (int k = 0; k < W; k++) dpk[(W-1-k)*8 +: 8] = dout[k];
        end

        int          n;
        logic [31:0] hist;
        logic [31:0] q[$];
        logic        pend;

        always @(negedge clk) begin
            if (rst) begin
                check($sformatf("d%0d ready_in during rst", g), 32'(rin[g]), 32'd0);
                q.delete();
                n    = 0;
                hist = '0;
            end else begin
                pend = (q.size() != 0);
                check($sformatf("d%0d valid_out", g), 32'(vout[g]), 32'(pend));
                check($sformatf("d%0d shift reg", g), dpk, hist);
                if (pend && vout[g]) check($sformatf("d%0d window", g), dpk, q[0]);
                check($sformatf("d%0d ready_in", g), 32'(rin[g]), 32'(!pend || rdo[g]));
                if (pend && rdo[g]) void'(q.pop_front());
                if (vin[g] && rin[g]) begin
                    hist = ((hist << 8) | 32'(din[g])) & MASK;
                    n++;
                    if (n >= W && ((n - W) % S) == 0) q.push_back(hist);
`ifdef SLIDING_WINDOW_FRAME_EN
                    if (lst[g]) n = 0;
`endif
                end
            end
        end
    end

    task automatic send(input int d, input int val, input bit last, input bit rnd);
        bit ok = 1'b0;
        vin[d] = 1'b1;
        din[d] = DATA_WIDTH'(val);
`ifdef SLIDING_WINDOW_FRAME_EN
        lst[d] = last;
`else
        if (last) $display("note: last ignored without frame support");
`endif
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rin[d]) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (rnd) rdo[d] = 1'($urandom_range(0, 1));
        end
        if (!ok) check($sformatf("d%0d send timeout", d), 32'd0, 32'd1);
        @(posedge clk);
        #1;
        vin[d] = 1'b0;
`ifdef SLIDING_WINDOW_FRAME_EN
        lst[d] = 1'b0;
`endif
        if (rnd) rdo[d] = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            vin[d] = 1'b0;
            din[d] = '0;
            rdo[d] = 1'b1;
`ifdef SLIDING_WINDOW_FRAME_EN
            lst[d] = 1'b0;
`endif
        end
        idle(3);
        rst = 1'b0;
        idle(2);

        // W3/S1 back-to-back stream
        for (int v = 1; v <= 5; v++) send(0, v, 1'b0, 1'b0);
        idle(4);
        // W3/S2
        for (int v = 1; v <= 7; v++) send(1, v, 1'b0, 1'b0);
        idle(4);
        // W4/S5: stride larger than window
        for (int v = 1; v <= 14; v++) send(2, v, 1'b0, 1'b0);
        idle(4);

        // Backpressure: window {1,2,3} held while ready_out is low, sample 4 waits
        pulse_rst();
        rdo[0] = 1'b0;
        for (int v = 1; v <= 3; v++) send(0, v, 1'b0, 1'b0);
        fork
            send(0, 4, 1'b0, 1'b0);
            begin
                idle(4);
                rdo[0] = 1'b1;
            end
        join
        idle(4);

        // Reset mid-fill discards partial window
        pulse_rst();
        send(0, 1, 1'b0, 1'b0);
        send(0, 2, 1'b0, 1'b0);
        pulse_rst();
        for (int v = 10; v <= 12; v++) send(0, v, 1'b0, 1'b0);
        idle(4);

        // Random data, gaps and ready_out on all configurations
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 25; i++) begin
                send(d, int'($urandom_range(0, 255)), 1'b0, 1'b1);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
            rdo[d] = 1'b1;
            idle(4);
        end

`ifdef SLIDING_WINDOW_FRAME_EN
        pulse_rst();
        for (int v = 1; v <= 4; v++) send(0, v, v == 4, 1'b0);
        for (int v = 5; v <= 7; v++) send(0, v, 1'b0, 1'b0);
        idle(4);
`endif

        idle(6);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
